// File: rtl/safe_adder_arb_pkg.sv
// Shared types and constant helpers for the safe_adder_arb arbitrated adder slice.
package safe_adder_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t RESP = 2'd2;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Two's-complement extremes for a given width, right-aligned in 64 bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/safe_adder_arb_if.sv
// Request/response bus of safe_adder_arb; slave modport is the arbiter side.
interface safe_adder_arb_if
    import safe_adder_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int A_WIDTH = 13,
    parameter int B_WIDTH = 13,
    parameter int Q_WIDTH = 13,
    parameter int ID_W    = id_width(N_REQ)
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*A_WIDTH-1:0] req_a;
    logic [N_REQ*B_WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [Q_WIDTH-1:0]       rsp_q;
    logic                     rsp_ovfl;
    logic [ID_W-1:0]          rsp_id;
    logic [N_REQ-1:0]         ovfl_sticky;
    logic [N_REQ-1:0]         ovfl_clr;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, ovfl_clr,
        output req_ready, rsp_valid, rsp_q, rsp_ovfl, rsp_id, ovfl_sticky
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, ovfl_clr,
        input  req_ready, rsp_valid, rsp_q, rsp_ovfl, rsp_id, ovfl_sticky
    );

endinterface

// File: rtl/safe_adder.sv
// Fixed-point add/subtract with binary-point alignment, LSB truncation and
// range-overflow detection; q is the wrapped two's-complement result.
module safe_adder #(
    parameter int A_WIDTH = 13,
    parameter int A_FRAC  = 8,
    parameter int B_WIDTH = 13,
    parameter int B_FRAC  = 8,
    parameter int Q_WIDTH = 13,
    parameter int Q_FRAC  = 8,
    parameter     OP      = "ADD"
) (
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [Q_WIDTH-1:0] q,
    output logic               ovfl
);
    localparam int  A_INT  = A_WIDTH - A_FRAC;
    localparam int  B_INT  = B_WIDTH - B_FRAC;
    localparam int  FRAC   = (A_FRAC > B_FRAC) ? A_FRAC : B_FRAC;
    localparam int  INT    = (A_INT > B_INT) ? A_INT : B_INT;
    localparam int  W      = INT + 1 + FRAC;
    localparam int  QSH_L  = (Q_FRAC > FRAC) ? (Q_FRAC - FRAC) : 0;
    localparam int  QSH_R  = (FRAC > Q_FRAC) ? (FRAC - Q_FRAC) : 0;
    localparam int  R      = (((W + QSH_L) > Q_WIDTH) ? (W + QSH_L) : Q_WIDTH) + 1;
    localparam bit  IS_SUB = (OP == "SUB");

    logic [W-1:0]       a_al, b_al, sum;
    logic [R-1:0]       sum_ext, scaled;
    logic [R-Q_WIDTH:0] upper;

    always_comb begin
        a_al    = {{(W - A_WIDTH){a[A_WIDTH-1]}}, a} << (FRAC - A_FRAC);
        b_al    = {{(W - B_WIDTH){b[B_WIDTH-1]}}, b} << (FRAC - B_FRAC);
        sum     = IS_SUB ? (a_al - b_al) : (a_al + b_al);
        sum_ext = {{(R - W){sum[W-1]}}, sum};
        // Rescale to the output binary point; dropped LSBs truncate toward -inf.
        scaled  = $signed(sum_ext << QSH_L) >>> QSH_R;
        upper   = scaled[R-1:Q_WIDTH-1];
        ovfl    = !((&upper) || !(|upper));
        q       = scaled[Q_WIDTH-1:0];
    end

endmodule

// File: rtl/safe_adder_arb_rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr and wraps from N-1 to 0.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);
    localparam int unsigned NU = N;

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = ID_W'((32'(ptr) + k) % NU);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/safe_adder_arb.sv
// Round-robin sharing of one safe_adder among N_REQ requesters with sticky overflow.
// Define SAFE_ADDER_ARB_SATURATE_EN to saturate rsp_q on overflow instead of wrapping.
module safe_adder_arb
    import safe_adder_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int A_WIDTH = 13,
    parameter int A_FRAC  = 8,
    parameter int B_WIDTH = 13,
    parameter int B_FRAC  = 8,
    parameter int Q_WIDTH = 13,
    parameter int Q_FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    safe_adder_arb_if.slave  bus
);
    localparam int ID_W = id_width(N_REQ);

    state_t             state;
    logic [ID_W-1:0]    ptr, gnt_idx, id_lat;
    logic [N_REQ-1:0]   gnt, sticky, sticky_set;
    logic [A_WIDTH-1:0] a_sel, a_lat;
    logic [B_WIDTH-1:0] b_sel, b_lat;
    logic [Q_WIDTH-1:0] sum_q, q_final, rsp_q_r;
    logic               sum_ovfl, rsp_valid_r, rsp_ovfl_r;
    logic [ID_W-1:0]    rsp_id_r;

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    always_comb begin
        bus.req_ready = (!rst && state == IDLE) ? gnt : '0;
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = bus.req_a[i*A_WIDTH +: A_WIDTH];
                b_sel = bus.req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    safe_adder #(
        .A_WIDTH (A_WIDTH),
        .A_FRAC  (A_FRAC),
        .B_WIDTH (B_WIDTH),
        .B_FRAC  (B_FRAC),
        .Q_WIDTH (Q_WIDTH),
        .Q_FRAC  (Q_FRAC),
        .OP      ("ADD")
    ) u_add (
        .a    (a_lat),
        .b    (b_lat),
        .q    (sum_q),
        .ovfl (sum_ovfl)
    );

`ifdef SAFE_ADDER_ARB_SATURATE_EN
    localparam int          A_INT = A_WIDTH - A_FRAC;
    localparam int          B_INT = B_WIDTH - B_FRAC;
    localparam int          FRAC  = max2(A_FRAC, B_FRAC);
    localparam int          FW    = max2(A_INT, B_INT) + 1 + FRAC;
    localparam logic [63:0] SMAX  = sat_max(Q_WIDTH);
    localparam logic [63:0] SMIN  = sat_min(Q_WIDTH);

    logic [FW-1:0] a_full, b_full, full_sum;

    // The full-precision sign picks the saturation rail; the wrapped sign is unreliable.
    always_comb begin
        a_full   = {{(FW - A_WIDTH){a_lat[A_WIDTH-1]}}, a_lat} << (FRAC - A_FRAC);
        b_full   = {{(FW - B_WIDTH){b_lat[B_WIDTH-1]}}, b_lat} << (FRAC - B_FRAC);
        full_sum = a_full + b_full;
        q_final  = sum_q;
        if (sum_ovfl)
            q_final = full_sum[FW-1] ? SMIN[Q_WIDTH-1:0] : SMAX[Q_WIDTH-1:0];
    end
`else
    always_comb begin
        q_final = sum_q;
    end
`endif

    always_comb begin
        sticky_set = '0;
        if (state == CALC && sum_ovfl)
            sticky_set[id_lat] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            id_lat      <= '0;
            a_lat       <= '0;
            b_lat       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_q_r     <= '0;
            rsp_ovfl_r  <= 1'b0;
            rsp_id_r    <= '0;
            sticky      <= '0;
        end else begin
            sticky <= sticky_set | (sticky & ~bus.ovfl_clr);
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        a_lat  <= a_sel;
                        b_lat  <= b_sel;
                        id_lat <= gnt_idx;
                        ptr    <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_q_r     <= q_final;
                    rsp_ovfl_r  <= sum_ovfl;
                    rsp_id_r    <= id_lat;
                    rsp_valid_r <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rsp_valid   = rsp_valid_r;
        bus.rsp_q       = rsp_q_r;
        bus.rsp_ovfl    = rsp_ovfl_r;
        bus.rsp_id      = rsp_id_r;
        bus.ovfl_sticky = sticky;
    end

endmodule

// File: tb/tb_safe_adder_arb.sv
// Scoreboard bench for safe_adder_arb at default parameters, Q(13,8).
module tb_safe_adder_arb;

    localparam int N   = 4;
    localparam int AW  = 13;
    localparam int BW  = 13;
    localparam int QW  = 13;
    localparam int IDW = 2;

    logic tb_clk = 1'b0;
    logic rst;

    always #5 tb_clk = ~tb_clk;

    safe_adder_arb_if #(.N_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .Q_WIDTH(QW), .ID_W(IDW)) bus ();

    safe_adder_arb #(
        .N_REQ(N), .A_WIDTH(AW), .A_FRAC(8), .B_WIDTH(BW), .B_FRAC(8), .Q_WIDTH(QW), .Q_FRAC(8)
    ) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [12:0] q;
        logic        ovfl;
        logic [1:0]  id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [12:0] a, input logic [12:0] b, input logic [1:0] id);
        logic signed [13:0] s;
        exp_t e;
        s      = $signed({a[12], a}) + $signed({b[12], b});
        e.id   = id;
        e.ovfl = (s > 14'sd4095) || (s < -14'sd4096);
        e.q    = s[12:0];
`ifdef SAFE_ADDER_ARB_SATURATE_EN
        if (e.ovfl) e.q = s[13] ? 13'h1000 : 13'h0FFF;
`endif
        return e;
    endfunction

    always @(negedge tb_clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got q=%h id=%0d, required no response", bus.rsp_q, bus.rsp_id);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.rsp_q, bus.rsp_ovfl, bus.rsp_id} !== mon_e) begin
                    n_bad++;
                    $display("FAIL rsp_data: got q=%h ovfl=%b id=%0d, required q=%h ovfl=%b id=%0d",
                             bus.rsp_q, bus.rsp_ovfl, bus.rsp_id, mon_e.q, mon_e.ovfl, mon_e.id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [12:0] a, input logic [12:0] b);
        bus.req_a[i*AW +: AW] = a;
        bus.req_b[i*BW +: BW] = b;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge tb_clk);
            #1;
            cyc++;
            if (bus.rsp_valid) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();
        @(negedge tb_clk);
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_req_ready: got %b, required 0000", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_q !== 13'h0) begin n_bad++; $display("FAIL rst_rsp_q: got %h, required 0000", bus.rsp_q); end
        n_cmp++; if ({bus.rsp_ovfl, bus.rsp_id} !== 3'b000) begin n_bad++; $display("FAIL rst_ovfl_id: got %b, required 000", {bus.rsp_ovfl, bus.rsp_id}); end
        n_cmp++; if (bus.ovfl_sticky !== 4'b0000) begin n_bad++; $display("FAIL rst_sticky: got %b, required 0000", bus.ovfl_sticky); end
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        set_req(0, 13'h0280, 13'h0842);
        bus.req_valid = 4'b0001;
        @(negedge tb_clk);
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL basic_grant: got %b, required 0001", bus.req_ready); end
        sb.push_back(model(13'h0280, 13'h0842, 2'd0));
        wait_rsp(cyc);
        bus.req_valid = '0;
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d, required 2", cyc); end
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        int cyc;
        set_req(2, 13'h0920, 13'h0920);
        bus.req_valid = 4'b0100;
        @(negedge tb_clk);
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL ovf_grant: got %b, required 0100", bus.req_ready); end
        sb.push_back(model(13'h0920, 13'h0920, 2'd2));
        wait_rsp(cyc);
        bus.req_valid = '0;
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL ovf_latency: got %0d, required 2", cyc); end
        n_cmp++; if (bus.ovfl_sticky !== 4'b0100) begin n_bad++; $display("FAIL ovf_sticky: got %b, required 0100", bus.ovfl_sticky); end
        repeat (2) tick();
    endtask

    task automatic test_sticky_clear();
        bus.ovfl_clr = 4'b0100;
        tick();
        bus.ovfl_clr = '0;
        @(negedge tb_clk);
        n_cmp++; if (bus.ovfl_sticky !== 4'b0000) begin n_bad++; $display("FAIL clr_alone: got %b, required 0000", bus.ovfl_sticky); end
        tick();
        bus.req_valid = 4'b0100;
        @(negedge tb_clk);
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL clr_grant: got %b, required 0100", bus.req_ready); end
        sb.push_back(model(13'h0920, 13'h0920, 2'd2));
        tick();
        bus.req_valid = '0;
        bus.ovfl_clr  = 4'b0100;
        tick();
        bus.ovfl_clr  = '0;
        @(negedge tb_clk);
        n_cmp++; if (bus.ovfl_sticky !== 4'b0100) begin n_bad++; $display("FAIL set_beats_clr: got %b, required 0100", bus.ovfl_sticky); end
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        logic [12:0] ra[4] = '{13'h0100, 13'h0200, 13'h0300, 13'h1F00};
        logic [12:0] rb[4] = '{13'h0010, 13'h0021, 13'h0032, 13'h1E80};
        int g;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, ra[i], rb[i]);
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            for (int t = 0; t < 10; t++) begin
                @(negedge tb_clk);
                if (bus.req_ready !== 4'b0000) break;
            end
            n_cmp++;
            if (bus.req_ready !== 4'(1 << g)) begin
                n_bad++;
                $display("FAIL rr_grant_%0d: got %b, required %b", k, bus.req_ready, 4'(1 << g));
            end
            if (bus.req_ready !== 4'b0000) sb.push_back(model(ra[g], rb[g], 2'(g)));
            tick();
        end
        bus.req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        exp_t e;
        e = model(13'h1000, 13'h1F00, 2'd3);
        bus.rsp_ready = 1'b0;
        set_req(3, 13'h1000, 13'h1F00);
        bus.req_valid = 4'b1000;
        @(negedge tb_clk);
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_grant: got %b, required 1000", bus.req_ready); end
        sb.push_back(e);
        tick();
        bus.req_valid = '1;
        wait_rsp(cyc);
        for (int c = 0; c < 5; c++) begin
            @(negedge tb_clk);
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_q, bus.rsp_id, bus.req_ready} !== {1'b1, e.q, 2'd3, 4'b0000}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got valid=%b q=%h id=%0d ready=%b, required valid=1 q=%h id=3 ready=0000",
                         c, bus.rsp_valid, bus.rsp_q, bus.rsp_id, bus.req_ready, e.q);
            end
        end
        tick();
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        tick();
        @(negedge tb_clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b, required 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_q !== e.q) begin n_bad++; $display("FAIL bp_q_kept: got %h, required %h", bus.rsp_q, e.q); end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bus.req_valid = 4'b0010;
        @(negedge tb_clk);
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_grant: got %b, required 0010", bus.req_ready); end
        tick();
        rst = 1'b1;
        bus.req_valid = '1;
        @(negedge tb_clk);
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready_in_rst: got %b, required 0000", bus.req_ready); end
        tick();
        rst = 1'b0;
        @(negedge tb_clk);
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_q, bus.rsp_ovfl, bus.rsp_id, bus.ovfl_sticky} !== '0) begin
            n_bad++;
            $display("FAIL mid_outputs: got valid=%b q=%h ovfl=%b id=%0d sticky=%b, required all zero",
                     bus.rsp_valid, bus.rsp_q, bus.rsp_ovfl, bus.rsp_id, bus.ovfl_sticky);
        end
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_regrant: got %b, required 0001", bus.req_ready); end
        if (bus.req_ready === 4'b0001) sb.push_back(model(13'h0100, 13'h0010, 2'd0));
        tick();
        bus.req_valid = '0;
        wait_rsp(cyc);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.ovfl_clr  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_sticky_clear();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
